cnt_bus_host: RTL and testbench
===============================

# cnt_bus_host

Bus-master controller for the 8-bit loadable counter's shared bidirectional data bus and its two control strobes (load, output-enable).
- Turns single-beat write (load) and read (sample count) commands from on-chip logic into correctly sequenced bus cycles, with guaranteed turnaround so host and counter never drive together.
- Returns each result on a valid/ready response channel.
- Sits between the command source and the counter's pins.

## Interface
Parameters:
- TURN, default 1, range 1..3: settle cycles with bus_oe=1 before the read sample.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = load cmd_data into counter, 0 = read counter.
- cmd_data  in  8  write data (ignored for reads).
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  8  read value or write result.
- rsp_err  out  1  write-verify mismatch (0 when feature compiled out).
- bus_load  out  1  to counter load strobe.
- bus_oe  out  1  to counter output-enable.
- bus_out  out  8  host-driven bus value.
- bus_drive  out  8  host output enables, all-ones or all-zeros.
- bus_in  in  8  bus sampled value.

## Operation
States: IDLE, WR_DRIVE, WR_GAP, RD_TURN, RD_SAMPLE, RSP.
- IDLE: load=0, oe=0, drive=0, cmd_ready=1. Accepted write goes to WR_DRIVE; accepted read goes to RD_TURN. cmd_data is latched into data register D.
- WR_DRIVE (1 cycle): bus_out=D, bus_drive=8'hFF, bus_load=1, bus_oe=0. Counter captures D at the closing edge.
  - Without verify: next state RSP, with rsp_data=D and rsp_err=0.
- WR_GAP (1 cycle, verify only): all strobes and drives 0 (bus turnaround). Next state is RD_TURN.
- RD_TURN (TURN cycles, internal down-counter): bus_oe=1, bus_drive=0.
- RD_SAMPLE (1 cycle): bus_oe=1. bus_in is registered into rsp_data at the closing edge. Next state RSP.
- RSP: bus_oe=0, bus_drive=0, rsp_valid=1. rsp_data and rsp_err are stable. Returns to IDLE on the rsp_ready edge.
- Bus-safety invariants:
  - bus_drive nonzero only in WR_DRIVE; bus_oe=1 only in RD_TURN/RD_SAMPLE.
  - bus_load and bus_oe are never both 1.
  - At least one cycle with both host drive and bus_oe deasserted separates any host-drive cycle from any bus_oe cycle, in either order.
- Verify expected value: E = D + 1 + TURN mod 256 (counter increments in WR_GAP and each RD_TURN cycle). rsp_err = (sample != E).
- Arithmetic is 8-bit, wraps silently.
- Commands offered outside IDLE are not accepted; cmd_valid may stay high.

## Timing
- Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, bus_load=0, bus_oe=0, bus_out=0, bus_drive=0. All outputs are registered or state-decoded.
- Reset mid-operation: the next edge with rst_n=0 forces reset values. A pending response is discarded; a partial bus cycle is abandoned with drives released that edge.
- Write latency (accept edge to rsp_valid): 2 cycles without verify; 3+TURN+1 with verify.
- Read latency: TURN+2 cycles.
- Back-to-back: minimum one IDLE cycle between commands. rsp_ready held high gives one command per (latency+1) cycles.
- rsp_ready=1 in the first RSP cycle means a one-cycle RSP.

## Configuration
- CNT_BUS_HOST_VERIFY_EN defined: every write is followed by WR_GAP and an automatic read-back. rsp_data = sampled value, rsp_err per the expected-value rule.
- Not defined: WR_GAP is unreachable. Writes respond with rsp_data=D and rsp_err=0; rsp_err is tied 0.

## Test plan
Bench pairs the block with a behavioural counter model (reset 0, load when load&!oe, else +1).
- Read after reset, TURN=1: read accepted at first IDLE edge -> rsp_data equals the model count during RD_SAMPLE, bus_oe high exactly 2 cycles, rsp_err=0.
- Write 0x5A, verify off -> rsp_valid 2 cycles after accept, rsp_data=0x5A, model count=0x5A at WR_DRIVE close.
- Write 0x5A, verify on, TURN=1 -> rsp_data=0x5C, rsp_err=0. Write 0xFF -> rsp_data=0x01 (wrap), rsp_err=0. With TURN=3, write 0x10 -> 0x14.
- Verify on, bench forces bus_in=0x00 during RD_SAMPLE of write 0x40 -> rsp_data=0x00, rsp_err=1.
- rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, no strobes; release -> IDLE next edge.
- rst_n low during RD_TURN and during WR_DRIVE -> next edge bus_oe=0, bus_drive=0, rsp_valid=0, state IDLE. Assertion checker confirms the bus-safety invariants throughout all tests.

Source files
------------

// File: rtl/cnt_bus_host.sv
// Bus master for the loadable 8-bit counter: sequences load/read bus cycles with turnaround.
// Latency: write 2 cycles (4+TURN with CNT_BUS_HOST_VERIFY_EN), read TURN+2, counted from the offer cycle.
// Backpressure: cmd_ready only in IDLE; response held in RSP until rsp_ready. Optional macro: CNT_BUS_HOST_VERIFY_EN.
module cnt_bus_host #(
    parameter int TURN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       bus_load,
    output logic       bus_oe,
    output logic [7:0] bus_out,
    output logic [7:0] bus_drive,
    input  logic [7:0] bus_in
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DRIVE,
        WR_GAP,
        RD_TURN,
        RD_SAMPLE,
        RSP
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] d_q;
    logic [1:0] turn_q;
    logic [7:0] rsp_data_q;

`ifdef CNT_BUS_HOST_VERIFY_EN
    // The counter keeps counting through WR_GAP and every RD_TURN cycle after the load.
    localparam logic [7:0] VERIFY_INC = 8'(TURN + 1);
    logic wr_q;
    logic rsp_err_q;
`endif

    // State, data latch, turnaround counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            d_q        <= 8'h00;
            turn_q     <= 2'd0;
            rsp_data_q <= 8'h00;
`ifdef CNT_BUS_HOST_VERIFY_EN
            wr_q       <= 1'b0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                d_q <= cmd_data;
`ifdef CNT_BUS_HOST_VERIFY_EN
                wr_q <= cmd_write;
`endif
            end
            // Reload on entry to RD_TURN, count down while there.
            if (state_nxt == RD_TURN && state != RD_TURN) begin
                turn_q <= 2'(TURN - 1);
            end else if (state == RD_TURN) begin
                turn_q <= turn_q - 2'd1;
            end
`ifndef CNT_BUS_HOST_VERIFY_EN
            if (state == WR_DRIVE) begin
                rsp_data_q <= d_q;
            end
`endif
            if (state == RD_SAMPLE) begin
                rsp_data_q <= bus_in;
`ifdef CNT_BUS_HOST_VERIFY_EN
                rsp_err_q  <= wr_q && (bus_in != 8'(d_q + VERIFY_INC));
`endif
            end
        end
    end

    // Next state and state-decoded bus/handshake outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_load  = 1'b0;
        bus_oe    = 1'b0;
        bus_out   = 8'h00;
        bus_drive = 8'h00;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = cmd_write ? WR_DRIVE : RD_TURN;
                end
            end
            WR_DRIVE: begin
                bus_out   = d_q;
                bus_drive = 8'hFF;
                bus_load  = 1'b1;
`ifdef CNT_BUS_HOST_VERIFY_EN
                state_nxt = WR_GAP;
`else
                state_nxt = RSP;
`endif
            end
            WR_GAP: begin
                state_nxt = RD_TURN;
            end
            RD_TURN: begin
                bus_oe = 1'b1;
                if (turn_q == 2'd0) begin
                    state_nxt = RD_SAMPLE;
                end
            end
            RD_SAMPLE: begin
                bus_oe    = 1'b1;
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rsp_data = rsp_data_q;
`ifdef CNT_BUS_HOST_VERIFY_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_bus_host.sv
// Bench for cnt_bus_host: two instances (TURN=1 and TURN=3), each paired with a counter model.
// Expected responses are queued when a command is driven and popped on the response handshake.
// Bus-safety invariants are checked every cycle while out of reset.
module tb_cnt_bus_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic       cmd_write [2];
    logic [7:0] cmd_data  [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic       bus_load  [2];
    logic       bus_oe    [2];
    logic [7:0] bus_out   [2];
    logic [7:0] bus_drive [2];
    logic [7:0] bus_in    [2];

    logic [7:0] cnt    [2];
    logic       force0 [2];
    logic       prev_drv [2];
    logic       prev_oe  [2];
    int         oe_cycles [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    cnt_bus_host #(.TURN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .bus_load(bus_load[0]), .bus_oe(bus_oe[0]), .bus_out(bus_out[0]), .bus_drive(bus_drive[0]),
        .bus_in(bus_in[0])
    );

    cnt_bus_host #(.TURN(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .bus_load(bus_load[1]), .bus_oe(bus_oe[1]), .bus_out(bus_out[1]), .bus_drive(bus_drive[1]),
        .bus_in(bus_in[1])
    );

    // Counter drives the bus only when output-enabled; force0 overrides what the host samples.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus_in[k] = force0[k] ? 8'h00 : (bus_oe[k] ? cnt[k] : 8'h00);
        end
    end

    // Behavioural counter: reset 0, load from the host-driven bus when load & !oe, else +1.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                cnt[k] <= 8'h00;
            end else if (bus_load[k] && !bus_oe[k]) begin
                cnt[k] <= bus_out[k] & bus_drive[k];
            end else begin
                cnt[k] <= cnt[k] + 8'h01;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Advance one cycle, sample after the edge and check bus-safety invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                chk("load_oe_excl", 32'(bus_load[k] & bus_oe[k]), 32'd0);
                chk("drive_legal", 32'(bus_drive[k] == 8'h00 || bus_drive[k] == 8'hFF), 32'd1);
                chk("turnaround", 32'((bus_oe[k] && (bus_drive[k] != 8'h00 || prev_drv[k]))
                                      || (bus_drive[k] != 8'h00 && prev_oe[k])), 32'd0);
                if (bus_oe[k]) oe_cycles[k]++;
            end
            prev_drv[k] = rst_n && (bus_drive[k] != 8'h00);
            prev_oe[k]  = rst_n && bus_oe[k];
        end
    endtask

    task automatic do_cmd(input int k, input bit wr, input logic [7:0] dat, input bit use_force, input int stall);
        int t, n, lat, oe_exp;
        logic [7:0] c2;
        exp_t e, got;
        t  = (k == 0) ? 1 : 3;
        c2 = ~dat;
        if (wr) begin
`ifdef CNT_BUS_HOST_VERIFY_EN
            e.d    = use_force ? 8'h00 : 8'(32'(dat) + 1 + t);
            e.e    = use_force;
            lat    = 4 + t;
            oe_exp = t + 1;
`else
            e.d    = dat;
            e.e    = 1'b0;
            lat    = 2;
            oe_exp = 0;
`endif
        end else begin
            e.d    = 8'(32'(cnt[k]) + t + 1);
            e.e    = 1'b0;
            lat    = t + 2;
            oe_exp = t + 1;
        end
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
        chk("cmd_ready_idle", 32'(cmd_ready[k]), 32'd1);
        force0[k]    = use_force;
        rsp_ready[k] = (stall == 0);
        oe_cycles[k] = 0;
        cmd_valid[k] = 1'b1;
        cmd_write[k] = wr;
        cmd_data[k]  = dat;
        tick();
        n = 1;
        cmd_valid[k] = 1'b0;
        cmd_data[k]  = 8'h00;
        while (rsp_valid[k] !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 2) c2 = cnt[k];
        end
        chk("rsp_latency", 32'(n), 32'(lat));
        if (wr) chk("load_value", 32'(c2), 32'(dat));
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
            chk("stall_data", 32'(rsp_data[k]), 32'(e.d));
            chk("stall_cmd_ready", 32'(cmd_ready[k]), 32'd0);
            chk("stall_strobes", {22'd0, bus_load[k], bus_oe[k], bus_drive[k]}, 32'd0);
            tick();
        end
        rsp_ready[k] = 1'b1;
        if (rsp_valid[k] === 1'b1) begin
            if (k == 0) got = sb0.pop_front(); else got = sb1.pop_front();
            chk("rsp_data", 32'(rsp_data[k]), 32'(got.d));
            chk("rsp_err", 32'(rsp_err[k]), 32'(got.e));
        end else begin
            chk("rsp_valid_seen", 32'(rsp_valid[k]), 32'd1);
        end
        tick();
        chk("back_to_idle", 32'(cmd_ready[k]), 32'd1);
        chk("rsp_released", 32'(rsp_valid[k]), 32'd0);
        chk("oe_cycles", 32'(oe_cycles[k]), 32'(oe_exp));
        chk("sb_drained", 32'((k == 0) ? sb0.size() : sb1.size()), 32'd0);
        force0[k] = 1'b0;
    endtask

    task automatic rst_mid(input int k, input bit wr);
        cmd_valid[k] = 1'b1;
        cmd_write[k] = wr;
        cmd_data[k]  = 8'hA5;
        tick();
        cmd_valid[k] = 1'b0;
        if (wr) begin
            chk("mid_drive", 32'(bus_drive[k]), 32'hFF);
        end else begin
            chk("mid_oe", 32'(bus_oe[k]), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        chk("rst_oe", 32'(bus_oe[k]), 32'd0);
        chk("rst_drive", 32'(bus_drive[k]), 32'd0);
        chk("rst_load", 32'(bus_load[k]), 32'd0);
        chk("rst_valid", 32'(rsp_valid[k]), 32'd0);
        chk("rst_idle", 32'(cmd_ready[k]), 32'd1);
        rst_n = 1'b1;
        sb0.delete();
        sb1.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_write[k] = 1'b0;
            cmd_data[k]  = 8'h00;
            rsp_ready[k] = 1'b1;
            force0[k]    = 1'b0;
            prev_drv[k]  = 1'b0;
            prev_oe[k]   = 1'b0;
            oe_cycles[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset_cmd_ready", 32'(cmd_ready[k]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("reset_rsp_data", 32'(rsp_data[k]), 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
            chk("reset_load_oe", {30'd0, bus_load[k], bus_oe[k]}, 32'd0);
            chk("reset_bus_out", 32'(bus_out[k]), 32'd0);
            chk("reset_bus_drive", 32'(bus_drive[k]), 32'd0);
        end
        rst_n = 1'b1;

        do_cmd(0, 1'b0, 8'h00, 1'b0, 0);   // read right after reset, TURN=1
        do_cmd(0, 1'b1, 8'h5A, 1'b0, 0);   // write 0x5A
        do_cmd(0, 1'b1, 8'hFF, 1'b0, 0);   // write 0xFF, verify wraps to 0x01
        do_cmd(1, 1'b1, 8'h10, 1'b0, 0);   // TURN=3 write 0x10
        do_cmd(1, 1'b0, 8'h00, 1'b0, 0);   // TURN=3 read
        do_cmd(0, 1'b1, 8'h40, 1'b1, 0);   // sampled value forced to 0x00
        do_cmd(0, 1'b0, 8'h00, 1'b0, 5);   // read with 5-cycle response stall
        do_cmd(1, 1'b1, 8'h77, 1'b0, 5);   // write with 5-cycle response stall

        rst_mid(0, 1'b0);                  // reset during RD_TURN
        rst_mid(1, 1'b0);
        rst_mid(0, 1'b1);                  // reset during WR_DRIVE
        do_cmd(0, 1'b0, 8'h00, 1'b0, 0);   // normal operation resumes

        for (int i = 0; i < 16; i++) begin
            do_cmd(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
